// File: rtl/df_ctrl_pkg.sv
// Shared constants and types for the dataflow job queue controller:
// register map, bit positions, response codes and the launch FSM state enum.
package df_ctrl_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_IEN    = 8'h08;
    localparam logic [7:0] REG_ISR    = 8'h0C;
    localparam logic [7:0] REG_ARG0   = 8'h10;

    localparam int CTRL_PUSH_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_FLUSH_BIT = 2;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_RUN_BIT   = 2;
    localparam int STAT_OVF_BIT   = 3;

    localparam int ISR_DONE_BIT  = 0;
    localparam int ISR_DRAIN_BIT = 1;
    localparam int ISR_OVF_BIT   = 2;

    localparam logic [7:0]  VERSION       = 8'hC1;
    localparam logic [31:0] BAD_ADDR_DATA = 32'h1BADADD2;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;

    localparam int JOB_N_ARGS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    typedef logic [JOB_N_ARGS-1:0][31:0] job_t;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/df_job_fifo.sv
// Circular job-descriptor store. A flush is applied before the pop/push of the same
// cycle, so a push accompanied by a flush or a pop always finds room.
module df_job_fifo
    import df_ctrl_pkg::*;
#(
    parameter int N_ARGS = 16,
    parameter int DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [N_ARGS-1:0][31:0]           push_data,
    input  logic                              pop,
    input  logic                              flush_all,
    input  logic                              flush_keep_head,
    output logic                              push_drop,
    output logic                              drained,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(DEPTH):0]            occupancy,
    output logic [N_ARGS-1:0][31:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N_ARGS-1:0][31:0] mem_r [DEPTH];
    logic [PW-1:0]           rd_ptr_r;
    logic [CW-1:0]           cnt_r;

    logic [CW-1:0] base_cnt_s;
    logic [CW-1:0] cnt_next_s;
    logic [PW-1:0] wr_idx_s;
    logic          pop_eff_s;
    logic          push_ok_s;

    // Occupancy after flush, then pop/push acceptance and the resulting count.
    always_comb begin
        base_cnt_s = cnt_r;
        if (flush_all) begin
            base_cnt_s = {CW{1'b0}};
        end else if (flush_keep_head) begin
            base_cnt_s = (cnt_r != {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b0}};
        end else begin
            base_cnt_s = cnt_r;
        end
        pop_eff_s  = pop && (base_cnt_s != {CW{1'b0}});
        push_ok_s  = push && ((base_cnt_s != CW'(DEPTH)) || pop_eff_s);
        push_drop  = push && !push_ok_s;
        wr_idx_s   = rd_ptr_r + base_cnt_s[PW-1:0];
        cnt_next_s = base_cnt_s - {{(CW-1){1'b0}}, pop_eff_s} + {{(CW-1){1'b0}}, push_ok_s};
        drained    = pop_eff_s && (cnt_next_s == {CW{1'b0}});
    end

    // Pointer, count and storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            cnt_r <= cnt_next_s;
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (push_ok_s) begin
                mem_r[wr_idx_s] <= push_data;
            end
        end
    end

    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == {CW{1'b0}});
    assign occupancy = cnt_r;
    assign head      = mem_r[rd_ptr_r];

endmodule

// File: rtl/df_job_queue_ctrl.sv
// AXI-lite programmed job queue that launches queued descriptors back-to-back
// to the dataflow FSM and reports completion, drain and overflow interrupts.
module df_job_queue_ctrl
    import df_ctrl_pkg::*;
#(
    parameter int N_ARGS              = 16,
    parameter int QUEUE_DEPTH         = 4,
    parameter int AXI_LITE_DATA_WIDTH = 32,
    parameter int AXI_LITE_ADDR_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     cfg_awaddr,
    input  logic                               cfg_awvalid,
    output logic                               cfg_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]     cfg_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0]   cfg_wstrb,
    input  logic                               cfg_wvalid,
    output logic                               cfg_wready,
    output logic [1:0]                         cfg_bresp,
    output logic                               cfg_bvalid,
    input  logic                               cfg_bready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     cfg_araddr,
    input  logic                               cfg_arvalid,
    output logic                               cfg_arready,
    output logic [AXI_LITE_DATA_WIDTH-1:0]     cfg_rdata,
    output logic [1:0]                         cfg_rresp,
    output logic                               cfg_rvalid,
    input  logic                               cfg_rready,
    output logic [N_ARGS-1:0][31:0]            job_args,
    output logic                               job_start,
    input  logic                               job_done,
    output logic                               irq_out
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    state_e                  state_r, next_state_s;
    logic [N_ARGS-1:0][31:0] stage_r;
    logic                    done_r, ovf_r, irq_r, job_start_r;
    logic [2:0]              ien_r, isr_r, isr_set_s;
    logic [15:0]             job_cnt_r;
    logic                    bvalid_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [31:0]             rdata_r;

    logic        wr_acc_s, rd_acc_s, w_ok_s, w_arg_hit_s, r_arg_hit_s;
    logic [7:0]  waddr_s, raddr_s;
    logic [5:0]  widx_s, ridx_s;
    logic [31:0] wmask_s, wd_s, rdata_s, arg_rd_s;
    logic [1:0]  rresp_s;
    logic        push_s, flush_s, done_clr_s, ovf_clr_s, ien_we_s;
    logic [2:0]  isr_clr_s;
    logic        pop_s, flush_all_s, flush_keep_s, running_s;
    logic        push_drop_s, drained_s, full_s, empty_s;
    logic [CW-1:0] occ_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^{cfg_awaddr[AXI_LITE_ADDR_WIDTH-1:8], cfg_araddr[AXI_LITE_ADDR_WIDTH-1:8]};

    assign wr_acc_s    = cfg_awvalid && cfg_wvalid && (!bvalid_r || cfg_bready);
    assign rd_acc_s    = cfg_arvalid && (!rvalid_r || cfg_rready);
    assign cfg_awready = wr_acc_s;
    assign cfg_wready  = wr_acc_s;
    assign cfg_arready = rd_acc_s;

    assign waddr_s     = cfg_awaddr[7:0];
    assign raddr_s     = cfg_araddr[7:0];
    assign widx_s      = waddr_s[7:2] - 6'd4;
    assign ridx_s      = raddr_s[7:2] - 6'd4;
    assign w_arg_hit_s = (waddr_s[1:0] == 2'b00) && (waddr_s >= REG_ARG0) && ({26'd0, widx_s} < 32'(N_ARGS));
    assign r_arg_hit_s = (raddr_s[1:0] == 2'b00) && (raddr_s >= REG_ARG0) && ({26'd0, ridx_s} < 32'(N_ARGS));
    assign wmask_s     = strb_mask(cfg_wstrb);
    assign wd_s        = cfg_wdata & wmask_s;

    // Write decode: strobed command bits and the OKAY/SLVERR decision.
    always_comb begin
        push_s     = 1'b0;
        flush_s    = 1'b0;
        done_clr_s = 1'b0;
        ovf_clr_s  = 1'b0;
        ien_we_s   = 1'b0;
        isr_clr_s  = 3'b000;
        w_ok_s     = 1'b0;
        if (wr_acc_s) begin
            case (waddr_s)
                REG_CTRL: begin
                    push_s     = wd_s[CTRL_PUSH_BIT];
                    done_clr_s = wd_s[CTRL_DONE_BIT];
                    flush_s    = wd_s[CTRL_FLUSH_BIT];
                    w_ok_s     = 1'b1;
                end
                REG_STATUS: begin
                    ovf_clr_s = wd_s[STAT_OVF_BIT];
                    w_ok_s    = 1'b1;
                end
                REG_IEN: begin
                    ien_we_s = 1'b1;
                    w_ok_s   = 1'b1;
                end
                REG_ISR: begin
                    isr_clr_s = wd_s[2:0];
                    w_ok_s    = 1'b1;
                end
                default: w_ok_s = w_arg_hit_s;
            endcase
        end else begin
            w_ok_s = 1'b0;
        end
    end

    // Staging argument selected by the read address.
    always_comb begin
        arg_rd_s = 32'h0;
        for (int i = 0; i < N_ARGS; i++) begin
            arg_rd_s = arg_rd_s | ((ridx_s == 6'(i)) ? stage_r[i] : 32'h0);
        end
    end

    // Read mux sampling register state at the acceptance cycle.
    always_comb begin
        rdata_s = 32'h0;
        rresp_s = RESP_OKAY;
        case (raddr_s)
            REG_CTRL: begin
                rdata_s[31:24]        = VERSION;
                rdata_s[CTRL_DONE_BIT] = done_r;
            end
            REG_STATUS: begin
                rdata_s[STAT_FULL_BIT]  = full_s;
                rdata_s[STAT_EMPTY_BIT] = empty_s;
                rdata_s[STAT_RUN_BIT]   = running_s;
                rdata_s[STAT_OVF_BIT]   = ovf_r;
                rdata_s[12:8]           = 5'(occ_s);
                rdata_s[31:16]          = job_cnt_r;
            end
            REG_IEN: rdata_s[2:0] = ien_r;
            REG_ISR: rdata_s[2:0] = isr_r;
            default: begin
                if (r_arg_hit_s) begin
                    rdata_s = arg_rd_s;
                end else begin
                    rdata_s = BAD_ADDR_DATA;
                    rresp_s = RESP_SLVERR;
                end
            end
        endcase
    end

    // Launch FSM next state; a flush in IDLE suppresses the launch decision.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !flush_all_s) begin
                    next_state_s = LAUNCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LAUNCH: next_state_s = RUN;
            RUN: begin
                if (job_done) begin
                    pop_s        = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    assign running_s    = (state_r != IDLE);
    assign flush_all_s  = flush_s && !running_s;
    assign flush_keep_s = flush_s && running_s;

    // Hardware interrupt causes for this cycle.
    always_comb begin
        isr_set_s                = 3'b000;
        isr_set_s[ISR_DONE_BIT]  = pop_s;
        isr_set_s[ISR_DRAIN_BIT] = drained_s;
        isr_set_s[ISR_OVF_BIT]   = push_drop_s;
    end

    df_job_fifo #(
        .N_ARGS (N_ARGS),
        .DEPTH  (QUEUE_DEPTH)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .push            (push_s),
        .push_data       (stage_r),
        .pop             (pop_s),
        .flush_all       (flush_all_s),
        .flush_keep_head (flush_keep_s),
        .push_drop       (push_drop_s),
        .drained         (drained_s),
        .full            (full_s),
        .empty           (empty_s),
        .occupancy       (occ_s),
        .head            (job_args)
    );

    // FSM state, launch pulse and interrupt output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            job_start_r <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            job_start_r <= (next_state_s == LAUNCH);
            irq_r       <= |(isr_r & ien_r);
        end
    end

    // Software-visible registers; a hardware set beats a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            ien_r     <= 3'b000;
            isr_r     <= 3'b000;
            job_cnt_r <= 16'h0000;
            for (int i = 0; i < N_ARGS; i++) begin
                stage_r[i] <= 32'h0;
            end
        end else begin
            done_r <= (done_r && !done_clr_s) || pop_s;
            ovf_r  <= (ovf_r && !ovf_clr_s) || push_drop_s;
            isr_r  <= (isr_r & ~isr_clr_s) | isr_set_s;
            if (ien_we_s) begin
                ien_r <= (ien_r & ~wmask_s[2:0]) | wd_s[2:0];
            end
            if (pop_s) begin
                job_cnt_r <= job_cnt_r + 16'd1;
            end
            for (int i = 0; i < N_ARGS; i++) begin
                if (wr_acc_s && w_arg_hit_s && (widx_s == 6'(i))) begin
                    stage_r[i] <= (stage_r[i] & ~wmask_s) | wd_s;
                end
            end
        end
    end

    // Single-entry B and R response slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= 32'h0;
        end else begin
            if (wr_acc_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= w_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if (cfg_bready) begin
                bvalid_r <= 1'b0;
            end
            if (rd_acc_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= rresp_s;
                rdata_r  <= rdata_s;
            end else if (cfg_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign cfg_bvalid = bvalid_r;
    assign cfg_bresp  = bresp_r;
    assign cfg_rvalid = rvalid_r;
    assign cfg_rresp  = rresp_r;
    assign cfg_rdata  = rdata_r;
    assign job_start  = job_start_r;
    assign irq_out    = irq_r;

endmodule

// File: tb/tb_df_job_queue_ctrl.sv
// Directed bench for df_job_queue_ctrl: expected launch arguments are queued when a
// push is issued and checked when job_start appears.
module tb_df_job_queue_ctrl;

    localparam int N_ARGS = 16;
    localparam int QD     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] cfg_awaddr, cfg_wdata, cfg_araddr, cfg_rdata;
    logic [3:0]  cfg_wstrb;
    logic cfg_awvalid, cfg_awready, cfg_wvalid, cfg_wready, cfg_bvalid, cfg_bready;
    logic cfg_arvalid, cfg_arready, cfg_rvalid, cfg_rready;
    logic [1:0] cfg_bresp, cfg_rresp;
    logic [N_ARGS-1:0][31:0] job_args;
    logic job_start, job_done, irq_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int last_start_cyc = -1;
    int start_count = 0;
    int done_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_d;
    logic [1:0]  rd_r;

    df_job_queue_ctrl #(.N_ARGS(N_ARGS), .QUEUE_DEPTH(QD), .AXI_LITE_DATA_WIDTH(32), .AXI_LITE_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cfg_awaddr(cfg_awaddr), .cfg_awvalid(cfg_awvalid), .cfg_awready(cfg_awready),
        .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb), .cfg_wvalid(cfg_wvalid), .cfg_wready(cfg_wready),
        .cfg_bresp(cfg_bresp), .cfg_bvalid(cfg_bvalid), .cfg_bready(cfg_bready),
        .cfg_araddr(cfg_araddr), .cfg_arvalid(cfg_arvalid), .cfg_arready(cfg_arready),
        .cfg_rdata(cfg_rdata), .cfg_rresp(cfg_rresp), .cfg_rvalid(cfg_rvalid), .cfg_rready(cfg_rready),
        .job_args(job_args), .job_start(job_start), .job_done(job_done), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every launch must match the oldest outstanding push.
    always @(negedge clk) begin
        if (job_start === 1'b1) begin
            start_count++;
            last_start_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_start", {31'd0, job_start}, 32'd0);
            else chk("start_arg0", job_args[0], exp_q.pop_front());
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        int n;
        n = 0;
        cfg_awaddr = {24'd0, a}; cfg_wdata = d; cfg_wstrb = s;
        cfg_awvalid = 1'b1; cfg_wvalid = 1'b1;
        @(negedge clk);
        while (!cfg_awready && n < 50) begin @(negedge clk); n++; end
        if (!cfg_awready) chk("aw_timeout", {31'd0, cfg_awready}, 32'd1);
        last_wr_cyc = cyc;
        @(posedge clk); #1;
        cfg_awvalid = 1'b0; cfg_wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cfg_bvalid && n < 50) begin @(negedge clk); n++; end
        chk("bresp", {29'd0, cfg_bvalid, cfg_bresp}, {29'd0, 1'b1, er});
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        cfg_araddr = {24'd0, a}; cfg_arvalid = 1'b1;
        @(negedge clk);
        while (!cfg_arready && n < 50) begin @(negedge clk); n++; end
        if (!cfg_arready) chk("ar_timeout", {31'd0, cfg_arready}, 32'd1);
        @(posedge clk); #1;
        cfg_arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cfg_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!cfg_rvalid) chk("r_timeout", {31'd0, cfg_rvalid}, 32'd1);
        d = cfg_rdata; r = cfg_rresp;
        @(posedge clk); #1;
    endtask

    task automatic pulse_done();
        job_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk); #1;
        job_done = 1'b0;
    endtask

    task automatic push_job(input logic [31:0] a0, input bit expect_launch);
        axi_write(8'h10, a0, 4'hF, 2'b00);
        if (expect_launch) exp_q.push_back(a0);
        axi_write(8'h00, 32'h1, 4'hF, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int acc;
        cfg_awaddr = 32'h0; cfg_wdata = 32'h0; cfg_wstrb = 4'h0; cfg_awvalid = 1'b0; cfg_wvalid = 1'b0;
        cfg_bready = 1'b1; cfg_araddr = 32'h0; cfg_arvalid = 1'b0; cfg_rready = 1'b1; job_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(1);

        // Reset state
        chk("rst_irq", {31'd0, irq_out}, 32'd0);
        chk("rst_job_start", {31'd0, job_start}, 32'd0);
        chk("rst_job_args0", job_args[0], 32'h0);
        chk("rst_bvalid", {31'd0, cfg_bvalid}, 32'd0);
        axi_read(8'h04, rd_d, rd_r);
        chk("rst_status", rd_d, 32'h0000_0002);
        axi_read(8'h00, rd_d, rd_r);
        chk("rst_ctrl", rd_d, 32'hC100_0000);

        // Single job
        axi_write(8'h08, 32'h1, 4'hF, 2'b00);
        axi_write(8'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        exp_q.push_back(32'hDEADBEEF);
        axi_write(8'h00, 32'h1, 4'hF, 2'b00);
        wait_cycles(3);
        chk("single_start_lat", 32'(last_start_cyc), 32'(last_wr_cyc + 2));
        chk("single_args_stable", job_args[0], 32'hDEADBEEF);
        pulse_done();
        wait_cycles(2);
        chk("single_irq", {31'd0, irq_out}, 32'd1);
        axi_read(8'h00, rd_d, rd_r);
        chk("single_ctrl_done", rd_d, 32'hC100_0002);
        axi_read(8'h04, rd_d, rd_r);
        chk("single_status", rd_d, 32'h0001_0002);
        axi_write(8'h0C, 32'h7, 4'hF, 2'b00);
        axi_write(8'h00, 32'h2, 4'hF, 2'b00);
        wait_cycles(2);
        chk("isr_clear_irq", {31'd0, irq_out}, 32'd0);
        axi_read(8'h00, rd_d, rd_r);
        chk("ctrl_done_cleared", rd_d, 32'hC100_0000);

        // Back-to-back with the FSM stalled
        for (int i = 1; i <= 4; i++) push_job(32'(i), 1'b1);
        wait_cycles(2);
        axi_read(8'h04, rd_d, rd_r);
        chk("b2b_status_full", rd_d, 32'h0001_0405);
        axi_write(8'h0C, 32'h7, 4'hF, 2'b00);
        for (int i = 0; i < 4; i++) begin
            pulse_done();
            sc = done_cyc;
            wait_cycles(4);
            if (i < 3) chk("b2b_start_lat", 32'(last_start_cyc), 32'(sc + 2));
            axi_read(8'h0C, rd_d, rd_r);
            chk("b2b_isr_drain", rd_d & 32'h2, (i == 3) ? 32'h2 : 32'h0);
        end

        // Overflow
        axi_write(8'h0C, 32'h7, 4'hF, 2'b00);
        for (int i = 1; i <= 4; i++) push_job(32'h100 + 32'(i), 1'b1);
        push_job(32'h105, 1'b0);
        axi_read(8'h04, rd_d, rd_r);
        chk("ovf_status", rd_d, 32'h0005_040D);
        axi_read(8'h0C, rd_d, rd_r);
        chk("ovf_isr2", rd_d & 32'h4, 32'h4);
        axi_write(8'h10, 32'h106, 4'hF, 2'b00);
        exp_q.push_back(32'h106);
        cfg_awaddr = 32'h0; cfg_wdata = 32'h1; cfg_wstrb = 4'hF;
        cfg_awvalid = 1'b1; cfg_wvalid = 1'b1; job_done = 1'b1;
        @(negedge clk);
        chk("ovf_pop_push_accept", {31'd0, cfg_awready}, 32'd1);
        @(posedge clk); #1;
        cfg_awvalid = 1'b0; cfg_wvalid = 1'b0; job_done = 1'b0;
        wait_cycles(2);
        axi_read(8'h04, rd_d, rd_r);
        chk("ovf_pop_push_occ", (rd_d >> 8) & 32'h1F, 32'd4);
        chk("ovf_pop_push_cnt", rd_d >> 16, 32'd6);
        axi_write(8'h04, 32'h8, 4'hF, 2'b00);
        axi_read(8'h04, rd_d, rd_r);
        chk("ovf_cleared", rd_d & 32'h8, 32'h0);
        repeat (4) begin
            pulse_done();
            wait_cycles(5);
        end

        // Flush with one running job and three queued
        for (int i = 1; i <= 4; i++) push_job(32'h200 + 32'(i), 1'b1);
        wait_cycles(2);
        axi_read(8'h04, rd_d, rd_r);
        chk("flush_pre_occ", (rd_d >> 8) & 32'h1F, 32'd4);
        exp_q.delete();
        axi_write(8'h00, 32'h4, 4'hF, 2'b00);
        axi_read(8'h04, rd_d, rd_r);
        chk("flush_post_occ", (rd_d >> 8) & 32'h1F, 32'd1);
        sc = start_count;
        pulse_done();
        wait_cycles(10);
        chk("flush_no_start", 32'(start_count), 32'(sc));
        axi_read(8'h04, rd_d, rd_r);
        chk("flush_status", rd_d, 32'h000B_0002);

        // Bus behaviour
        axi_read(8'h80, rd_d, rd_r);
        chk("unmapped_rdata", rd_d, 32'h1BADADD2);
        chk("unmapped_rresp", {30'd0, rd_r}, 32'd2);
        axi_write(8'h80, 32'h0, 4'hF, 2'b10);
        cfg_bready = 1'b0;
        cfg_awaddr = 32'h8; cfg_wdata = 32'h1; cfg_wstrb = 4'hF; cfg_awvalid = 1'b1; cfg_wvalid = 1'b1;
        @(negedge clk);
        chk("bp_first_accept", {31'd0, cfg_awready}, 32'd1);
        @(posedge clk); #1;
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            if (cfg_awready) acc = 1;
        end
        chk("bp_blocked", 32'(acc), 32'd0);
        chk("bp_bvalid_held", {31'd0, cfg_bvalid}, 32'd1);
        @(posedge clk); #1;
        cfg_bready = 1'b1;
        @(negedge clk);
        chk("bp_accept_on_bready", {31'd0, cfg_awready}, 32'd1);
        @(posedge clk); #1;
        cfg_awvalid = 1'b0; cfg_wvalid = 1'b0;
        wait_cycles(2);
        axi_write(8'h14, 32'h11223344, 4'hF, 2'b00);
        axi_write(8'h14, 32'hAABBCCDD, 4'h2, 2'b00);
        axi_read(8'h14, rd_d, rd_r);
        chk("wstrb_arg1", rd_d, 32'h1122CC44);

        // Reset during a running job
        push_job(32'h77, 1'b1);
        wait_cycles(3);
        chk("mid_args", job_args[0], 32'h77);
        sc = start_count;
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        exp_q.delete();
        chk("mid_rst_args", job_args[0], 32'h0);
        pulse_done();
        wait_cycles(6);
        chk("mid_rst_no_start", 32'(start_count), 32'(sc));
        axi_read(8'h04, rd_d, rd_r);
        chk("mid_rst_status", rd_d, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
